dtw_core_ctrl: RTL and testbench
================================

Name: dtw_core_ctrl

Overview:
Sequencer for one DTW core datapath: accepts a query start, streams SQG_LEN squiggle samples into the datapath's squiggle buffer, then streams the reference and drains the PE chain until the datapath reports done. It then returns (best_score, best_position) on a result handshake. It sits between the host/DMA stream interfaces and a single DTW core datapath instance, and owns that datapath's reset, run-enable and load strobes.

Parameters:
WORD_LEN, 16, sample/score width; must match datapath
SQG_LEN, 250, squiggle samples per query; must match datapath
TIMEOUT_CYCLES, 65535, stall limit used only with DTW_CTRL_TIMEOUT_EN

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  query start pulse; accepted only in IDLE
ref_len  in  32  reference length; latched on accepted start
busy  out  1  high in every state except IDLE
sqg_valid / sqg_ready  in/out  1/1  squiggle stream handshake
sqg_data  in  WORD_LEN  squiggle sample
ref_valid / ref_ready  in/out  1/1  reference stream handshake
ref_data  in  WORD_LEN  reference sample
dp_rst  out  1  datapath reset
dp_running  out  1  datapath run enable
dp_load_squiggle  out  1  datapath squiggle load strobe
dp_squiggle_word  out  WORD_LEN  equals sqg_data
dp_reference_word  out  WORD_LEN  ref_data while streaming, else 0
dp_reference_len  out  32  latched ref_len
dp_done  in  1  datapath done
dp_best_score  in  WORD_LEN  datapath best score
dp_best_position  in  32  datapath best position
res_valid / res_ready  out/in  1/1  result handshake
res_score  out  WORD_LEN  captured best score
res_position  out  32  captured best position
res_error  out  1  query aborted by timeout; always 0 without the macro

Behaviour:
- Reset (rst=1): state IDLE; busy=0, sqg_ready=0, ref_ready=0, dp_running=0, dp_load_squiggle=0, res_valid=0, res_error=0. res_score=all-ones, res_position=0, counters=0, dp_reference_len=0. dp_rst=1 for the whole reset. Reset mid-query abandons the query immediately; no result is produced.
- States: IDLE, CLEAR, LOAD, RUN, DRAIN, SETTLE, RESULT.
- IDLE: start=1 latches ref_len. If ref_len==0, go to RESULT with res_score=all-ones, res_position=0; the datapath is not touched. Otherwise go to CLEAR.
- CLEAR: exactly 1 cycle; dp_rst=1; sqg_cnt=0 and ref_cnt=0. Next state is LOAD.
- LOAD: sqg_ready=1. Each sqg_valid&&sqg_ready pulses dp_load_squiggle in the same cycle (combinational) and increments sqg_cnt. When the SQG_LEN-th word is accepted, go to RUN. sqg_ready=0 in every other state.
- RUN: ref_ready=1. dp_running = ref_valid (one datapath step per accepted word; stalls freeze the datapath). ref_cnt increments per handshake. When the accepted word has ref_cnt==ref_len-1, go to DRAIN.
- DRAIN: ref_ready=0; dp_running=1; dp_reference_word=0. Leave for SETTLE in the cycle dp_done is sampled 1.
- SETTLE: exactly 2 cycles, dp_running=0. This lets dtw_score and the best-score compare retire. Next state is RESULT.
- RESULT: on entry, register res_score/res_position from dp_best_*, or use the zero-length values. res_valid=1, held stable until res_ready=1. In the handshake cycle, res_valid falls on the next edge and the state goes to IDLE. res_valid=1 and res_ready=1 in the same cycle completes in one cycle.
- start outside IDLE is ignored with no side effect.
- dp_reference_len stays stable from CLEAR through RESULT.
- Counters are 32-bit and cannot wrap, since ref_len ≤ 2^32-1.

Optional Feature:
Macro DTW_CTRL_TIMEOUT_EN.
- With the macro: a 32-bit stall counter runs in LOAD and RUN. It clears on any stream handshake or state change and increments in cycles with no handshake. When it reaches TIMEOUT_CYCLES, go to RESULT with res_error=1, res_score=all-ones, res_position=0. dp_rst=1 for that transition cycle.
- Without the macro: no counter exists, res_error is tied to 0, and the block waits indefinitely.

Test Plan:
1. SQG_LEN=4, ref_len=8, streams always valid, real datapath, squiggle {10,20,30,40}, reference with the exact subsequence at positions 2..5 -> 4 dp_load_squiggle pulses, 8 ref handshakes, res_valid with res_score=0 and res_position equal to the datapath's reported position; busy falls after res_ready.
2. Same stimulus with ref_valid toggling 1-0-0-1 -> dp_running low on every stall cycle; result identical to test 1.
3. ref_len=0 -> no dp_rst pulse after reset, 0 load pulses, res_valid within 2 cycles, res_score=16'hFFFF, res_position=0.
4. rst asserted mid-RUN after 3 reference words -> next cycle: state IDLE, busy=0, dp_running=0, res_valid never asserted; a new start then completes normally.
5. res_ready held 0 for 5 cycles in RESULT; start pulsed meanwhile -> res_valid and res_score stable throughout, start ignored, IDLE one cycle after res_ready=1.
6. DTW_CTRL_TIMEOUT_EN, TIMEOUT_CYCLES=16, sqg_valid stuck 0 after 2 words -> res_valid after 16 idle cycles with res_error=1, res_score=16'hFFFF.

Source files
------------

// File: rtl/dtw_core_ctrl.sv
// dtw_core_ctrl: sequences one DTW core datapath through clear, squiggle load, reference run, drain and result.
// Optional stall timeout enabled by defining DTW_CTRL_TIMEOUT_EN.
module dtw_core_ctrl #(
    parameter int WORD_LEN       = 16,
    parameter int SQG_LEN        = 250,
    parameter int TIMEOUT_CYCLES = 65535
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [31:0]         ref_len,
    output logic                busy,
    input  logic                sqg_valid,
    output logic                sqg_ready,
    input  logic [WORD_LEN-1:0] sqg_data,
    input  logic                ref_valid,
    output logic                ref_ready,
    input  logic [WORD_LEN-1:0] ref_data,
    output logic                dp_rst,
    output logic                dp_running,
    output logic                dp_load_squiggle,
    output logic [WORD_LEN-1:0] dp_squiggle_word,
    output logic [WORD_LEN-1:0] dp_reference_word,
    output logic [31:0]         dp_reference_len,
    input  logic                dp_done,
    input  logic [WORD_LEN-1:0] dp_best_score,
    input  logic [31:0]         dp_best_position,
    output logic                res_valid,
    input  logic                res_ready,
    output logic [WORD_LEN-1:0] res_score,
    output logic [31:0]         res_position,
    output logic                res_error
);
    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, RUN, DRAIN, SETTLE, RESULT} state_t;
    state_t      state, state_n;
    logic [31:0] sqg_cnt, ref_cnt, ref_len_q;
    logic        settle_q, sqg_hs, ref_hs, timeout, zero_start;
    assign sqg_ready         = state == LOAD;
    assign ref_ready         = state == RUN;
    assign sqg_hs            = sqg_valid && sqg_ready;
    assign ref_hs            = ref_valid && ref_ready;
    assign busy              = state != IDLE;
    assign res_valid         = state == RESULT;
    assign dp_load_squiggle  = sqg_hs;
    assign dp_running        = ref_ready ? ref_valid : state == DRAIN;
    assign dp_squiggle_word  = sqg_data;
    assign dp_reference_word = ref_ready ? ref_data : '0;
    assign dp_reference_len  = ref_len_q;
    assign dp_rst            = rst || state == CLEAR || timeout;
    assign zero_start        = state == IDLE && start && ref_len == 32'd0;
`ifdef DTW_CTRL_TIMEOUT_EN
    logic [31:0] stall_cnt;
    logic        err_q;
    // Any handshake or state change restarts the stall window.
    assign timeout   = (state == LOAD || state == RUN) && !sqg_hs && !ref_hs && stall_cnt == 32'(TIMEOUT_CYCLES - 1);
    assign res_error = err_q;
    always_ff @(posedge clk) begin
        stall_cnt <= (rst || state_n != state || sqg_hs || ref_hs) ? '0 : stall_cnt + 32'd1;
        err_q     <= rst ? 1'b0 : timeout ? 1'b1 : (state == IDLE && start) ? 1'b0 : err_q;
    end
`else
    assign timeout   = 1'b0;
    assign res_error = 1'b0;
`endif
    always_comb begin
        state_n = state;
        unique case (state)
            IDLE:    state_n = start ? (ref_len == 32'd0 ? RESULT : CLEAR) : IDLE;
            CLEAR:   state_n = LOAD;
            LOAD:    state_n = (sqg_hs && sqg_cnt == 32'(SQG_LEN - 1)) ? RUN : LOAD;
            RUN:     state_n = (ref_hs && ref_cnt == ref_len_q - 32'd1) ? DRAIN : RUN;
            DRAIN:   state_n = dp_done ? SETTLE : DRAIN;
            SETTLE:  state_n = settle_q ? RESULT : SETTLE;
            RESULT:  state_n = res_ready ? IDLE : RESULT;
            default: state_n = IDLE;
        endcase
        if (timeout) state_n = RESULT;
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            sqg_cnt      <= '0;
            ref_cnt      <= '0;
            ref_len_q    <= '0;
            settle_q     <= 1'b0;
            res_score    <= '1;
            res_position <= '0;
        end else begin
            state    <= state_n;
            sqg_cnt  <= state == CLEAR ? '0 : sqg_hs ? sqg_cnt + 32'd1 : sqg_cnt;
            ref_cnt  <= state == CLEAR ? '0 : ref_hs ? ref_cnt + 32'd1 : ref_cnt;
            settle_q <= state == SETTLE && !settle_q;
            if (state == IDLE && start) ref_len_q <= ref_len;
            // Capture on the last settle cycle, once the best-score compare has retired.
            if (state == SETTLE && settle_q) begin
                res_score    <= dp_best_score;
                res_position <= dp_best_position;
            end else if (zero_start || timeout) begin
                res_score    <= '1;
                res_position <= '0;
            end
        end
    end
endmodule

// File: tb/tb_dtw_core_ctrl.sv
// tb_dtw_core_ctrl: directed bench for dtw_core_ctrl with a mock datapath (score 0 at position 5 once drained).
module tb_dtw_core_ctrl;
    logic        clk = 0, rst = 1, start = 0;
    logic [31:0] ref_len = 0;
    logic        busy, sqg_valid = 0, sqg_ready, ref_valid = 0, ref_ready;
    logic [15:0] sqg_data = 0, ref_data = 0;
    logic        dp_rst, dp_running, dp_load_squiggle, dp_done;
    logic [15:0] dp_squiggle_word, dp_reference_word, dp_best_score, res_score;
    logic [31:0] dp_reference_len, dp_best_position, res_position;
    logic        res_valid, res_ready = 0, res_error;
    int checks = 0, errors = 0;
    int nload = 0, nref = 0, nrun = 0, nrst = 0, nres = 0, bad_run = 0, nstall = 0, dcnt = 0;
    logic [15:0] sqg_log [256];
    logic [15:0] ref_log [256];
    logic [15:0] sq [4]  = '{16'd10, 16'd20, 16'd30, 16'd40};
    logic [15:0] rf [8]  = '{16'd5, 16'd7, 16'd10, 16'd20, 16'd30, 16'd40, 16'd3, 16'd9};
    always #5 clk = ~clk;
    dtw_core_ctrl #(.WORD_LEN(16), .SQG_LEN(4), .TIMEOUT_CYCLES(16)) dut (
        .clk(clk), .rst(rst), .start(start), .ref_len(ref_len), .busy(busy),
        .sqg_valid(sqg_valid), .sqg_ready(sqg_ready), .sqg_data(sqg_data),
        .ref_valid(ref_valid), .ref_ready(ref_ready), .ref_data(ref_data),
        .dp_rst(dp_rst), .dp_running(dp_running), .dp_load_squiggle(dp_load_squiggle),
        .dp_squiggle_word(dp_squiggle_word), .dp_reference_word(dp_reference_word),
        .dp_reference_len(dp_reference_len), .dp_done(dp_done), .dp_best_score(dp_best_score),
        .dp_best_position(dp_best_position), .res_valid(res_valid), .res_ready(res_ready),
        .res_score(res_score), .res_position(res_position), .res_error(res_error)
    );
    // Mock datapath: done after three drain steps, then reports the exact match.
    assign dp_done          = dcnt >= 3;
    assign dp_best_score    = dp_done ? 16'd0 : 16'h0BAD;
    assign dp_best_position = dp_done ? 32'd5 : 32'hDEAD;
    always @(posedge clk) begin
        dcnt <= dp_rst ? 0 : (dp_running && !ref_ready) ? dcnt + 1 : dcnt;
        if (!rst) begin
            if (dp_load_squiggle) begin sqg_log[nload[7:0]] <= dp_squiggle_word; nload <= nload + 1; end
            if (dp_running && ref_ready) begin ref_log[nref[7:0]] <= dp_reference_word; nref <= nref + 1; end
            if (dp_running) nrun <= nrun + 1;
            if (dp_running && ref_ready && !ref_valid) bad_run <= bad_run + 1;
            if (ref_ready && !ref_valid) nstall <= nstall + 1;
            if (dp_rst) nrst <= nrst + 1;
            if (res_valid) nres <= nres + 1;
        end
    end
    task automatic pulse_start(input logic [31:0] len);
        @(negedge clk); start = 1; ref_len = len;
        @(negedge clk); start = 0;
    endtask
    task automatic stream(input bit toggle, input int stop_refs, output bit ok);
        int si = 0, ri = 0;
        ok = 0;
        for (int c = 0; c < 200; c++) begin
            if (res_valid || ri >= stop_refs) begin ok = 1; break; end
            sqg_valid = si < 4;
            sqg_data  = si < 4 ? sq[si] : 16'd0;
            ref_valid = ri < 8 && (!toggle || c % 4 == 0 || c % 4 == 3);
            ref_data  = ri < 8 ? rf[ri] : 16'd0;
            if (sqg_valid && sqg_ready) si++;
            if (ref_valid && ref_ready) ri++;
            @(negedge clk);
        end
        sqg_valid = 0; ref_valid = 0;
    endtask
    task automatic finish_result();
        res_ready = 1;
        @(negedge clk); res_ready = 0;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after_ack got %b want 0", busy); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL res_valid_after_ack got %b want 0", res_valid); end
    endtask
    task automatic check_query(input string name, input int l0, input int r0, input int u0);
        checks++; if (nload - l0 !== 4) begin errors++; $display("FAIL %s loads got %0d want 4", name, nload - l0); end
        checks++; if (nref - r0 !== 8) begin errors++; $display("FAIL %s refs got %0d want 8", name, nref - r0); end
        checks++; if (nrun - u0 !== 12) begin errors++; $display("FAIL %s run_steps got %0d want 12", name, nrun - u0); end
        for (int i = 0; i < 4; i++) begin
            checks++; if (sqg_log[8'(l0 + i)] !== sq[i]) begin errors++; $display("FAIL %s sqg_word%0d got %0d want %0d", name, i, sqg_log[8'(l0 + i)], sq[i]); end
        end
        for (int i = 0; i < 8; i++) begin
            checks++; if (ref_log[8'(r0 + i)] !== rf[i]) begin errors++; $display("FAIL %s ref_word%0d got %0d want %0d", name, i, ref_log[8'(r0 + i)], rf[i]); end
        end
        checks++; if (res_score !== 16'd0) begin errors++; $display("FAIL %s res_score got %h want 0000", name, res_score); end
        checks++; if (res_position !== 32'd5) begin errors++; $display("FAIL %s res_position got %0d want 5", name, res_position); end
        checks++; if (res_error !== 1'b0) begin errors++; $display("FAIL %s res_error got %b want 0", name, res_error); end
        checks++; if (dp_reference_len !== 32'd8) begin errors++; $display("FAIL %s ref_len got %0d want 8", name, dp_reference_len); end
    endtask
    task automatic test_reset();
        rst = 1;
        repeat (3) @(negedge clk);
        checks++; if ({busy, sqg_ready, ref_ready, dp_running, dp_load_squiggle, res_valid, res_error} !== 7'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 0000000", {busy, sqg_ready, ref_ready, dp_running, dp_load_squiggle, res_valid, res_error}); end
        checks++; if (dp_rst !== 1'b1) begin errors++; $display("FAIL reset_dp_rst got %b want 1", dp_rst); end
        checks++; if (res_score !== 16'hFFFF) begin errors++; $display("FAIL reset_score got %h want ffff", res_score); end
        checks++; if (res_position !== 32'd0) begin errors++; $display("FAIL reset_position got %0d want 0", res_position); end
        checks++; if (dp_reference_len !== 32'd0) begin errors++; $display("FAIL reset_ref_len got %0d want 0", dp_reference_len); end
        rst = 0;
        @(negedge clk);
    endtask
    task automatic test_basic(input bit toggle, input string name);
        int l0 = nload, r0 = nref, u0 = nrun, b0 = bad_run, s0 = nstall;
        bit ok;
        pulse_start(8);
        stream(toggle, 99, ok);
        checks++; if (!ok) begin errors++; $display("FAIL %s timeout got no res_valid want res_valid", name); end
        check_query(name, l0, r0, u0);
        checks++; if (bad_run - b0 !== 0) begin errors++; $display("FAIL %s run_on_stall got %0d want 0", name, bad_run - b0); end
        if (toggle) begin
            checks++; if (nstall - s0 < 1) begin errors++; $display("FAIL %s stalls got %0d want >0", name, nstall - s0); end
        end
        finish_result();
    endtask
    task automatic test_zero_len();
        int l0 = nload, d0 = nrst;
        pulse_start(0);
        checks++; if (res_valid !== 1'b1) begin errors++; $display("FAIL zero_res_valid got %b want 1", res_valid); end
        checks++; if (res_score !== 16'hFFFF) begin errors++; $display("FAIL zero_score got %h want ffff", res_score); end
        checks++; if (res_position !== 32'd0) begin errors++; $display("FAIL zero_position got %0d want 0", res_position); end
        checks++; if (nrst - d0 !== 0) begin errors++; $display("FAIL zero_dp_rst got %0d want 0", nrst - d0); end
        checks++; if (nload - l0 !== 0) begin errors++; $display("FAIL zero_loads got %0d want 0", nload - l0); end
        finish_result();
    endtask
    task automatic test_reset_mid_run();
        int q0, l0, r0, u0;
        bit ok;
        pulse_start(8);
        stream(0, 3, ok);
        q0 = nres;
        rst = 1;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_busy got %b want 0", busy); end
        checks++; if (dp_running !== 1'b0) begin errors++; $display("FAIL abort_running got %b want 0", dp_running); end
        checks++; if (res_valid !== 1'b0) begin errors++; $display("FAIL abort_res_valid got %b want 0", res_valid); end
        rst = 0;
        repeat (3) @(negedge clk);
        checks++; if (nres - q0 !== 0) begin errors++; $display("FAIL abort_results got %0d want 0", nres - q0); end
        l0 = nload; r0 = nref; u0 = nrun;
        pulse_start(8);
        stream(0, 99, ok);
        checks++; if (!ok) begin errors++; $display("FAIL after_abort timeout got no res_valid want res_valid"); end
        check_query("after_abort", l0, r0, u0);
        finish_result();
    endtask
    task automatic test_back_pressure();
        bit ok;
        pulse_start(8);
        stream(0, 99, ok);
        for (int i = 0; i < 5; i++) begin
            start = i == 2; ref_len = 32'd3;
            checks++; if (res_valid !== 1'b1 || res_score !== 16'd0 || res_position !== 32'd5) begin
                errors++; $display("FAIL hold%0d got v=%b s=%h p=%0d want v=1 s=0000 p=5", i, res_valid, res_score, res_position); end
            checks++; if (dp_reference_len !== 32'd8) begin errors++; $display("FAIL hold%0d ref_len got %0d want 8", i, dp_reference_len); end
            @(negedge clk);
        end
        start = 0;
        finish_result();
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignored_start busy got %b want 0", busy); end
    endtask
`ifdef DTW_CTRL_TIMEOUT_EN
    task automatic test_timeout();
        int si = 0, n = 0;
        pulse_start(8);
        while (si < 2 && n < 20) begin
            sqg_valid = 1; sqg_data = sq[si];
            if (sqg_ready) si++;
            n++;
            @(negedge clk);
        end
        sqg_valid = 0;
        n = 0;
        while (!res_valid && n < 40) begin n++; @(negedge clk); end
        checks++; if (n !== 16) begin errors++; $display("FAIL timeout_cycles got %0d want 16", n); end
        checks++; if (res_error !== 1'b1) begin errors++; $display("FAIL timeout_error got %b want 1", res_error); end
        checks++; if (res_score !== 16'hFFFF || res_position !== 32'd0) begin
            errors++; $display("FAIL timeout_result got s=%h p=%0d want s=ffff p=0", res_score, res_position); end
        finish_result();
    endtask
`endif
    initial begin
        test_reset();
        test_basic(0, "basic");
        test_basic(1, "toggle");
        test_zero_len();
        test_reset_mid_run();
        test_back_pressure();
`ifdef DTW_CTRL_TIMEOUT_EN
        test_timeout();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
